// File: rtl/blft_pkg.sv
// blft_pkg: shared constants and weight helpers for the 3x3 bilateral filter.
package blft_pkg;
    localparam int IMG_W = 256;
    localparam int DATA_W = 9;
    localparam int ADDR_W = 16;
    localparam int NUM_W = 16;
    localparam int DEN_W = 8;
    localparam int W_W = 6;
    localparam int PROD_W = W_W + DATA_W;
    localparam int LATENCY = 12;
    // window, weight and sum stages precede the divider, the output register follows it
    localparam int DIV_STAGES = LATENCY - 3;
    localparam logic [DATA_W-1:0] TH0 = DATA_W'(8);
    localparam logic [DATA_W-1:0] TH1 = DATA_W'(16);
    localparam logic [DATA_W-1:0] TH2 = DATA_W'(32);
    localparam logic [DATA_W-1:0] TH3 = DATA_W'(64);
    localparam logic [W_W-1:0] WR0 = W_W'(8);
    localparam logic [W_W-1:0] WR1 = W_W'(4);
    localparam logic [W_W-1:0] WR2 = W_W'(2);
    localparam logic [W_W-1:0] WR3 = W_W'(1);
    localparam logic [W_W-1:0] WS_CTR = W_W'(4);
    localparam logic [W_W-1:0] WS_EDGE = W_W'(2);
    localparam logic [W_W-1:0] WS_CORNER = W_W'(1);

    function automatic logic [W_W-1:0] range_w(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] c);
        logic [DATA_W-1:0] d;
        d = a > c ? a - c : c - a;
        return d < TH0 ? WR0 : d < TH1 ? WR1 : d < TH2 ? WR2 : d < TH3 ? WR3 : '0;
    endfunction

    // window index k = row*3 + col: centre 4, edges odd, corners even
    function automatic logic [W_W-1:0] ws_of(input int k);
        return k == 4 ? WS_CTR : k % 2 == 1 ? WS_EDGE : WS_CORNER;
    endfunction
endpackage

// File: rtl/blft_div.sv
// blft_div: pipelined restoring divider, one quotient bit per stage, tag carried alongside.
module blft_div #(
    parameter int NUM_W = 16,
    parameter int DEN_W = 8,
    parameter int Q_W = 9,
    parameter int TAG_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [NUM_W-1:0] num,
    input  logic [DEN_W-1:0] den,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    output logic [Q_W-1:0]   quo,
    output logic [TAG_W-1:0] out_tag
);
    logic [Q_W-1:0] vld;
    logic [DEN_W-1:0] rem [Q_W];
    logic [DEN_W-1:0] dq [Q_W];
    logic [NUM_W-1:0] nq [Q_W];
    logic [Q_W-1:0] qq [Q_W];
    logic [TAG_W-1:0] tq [Q_W];

    function automatic logic [DEN_W:0] step(input logic [DEN_W-1:0] r, input logic b, input logic [DEN_W-1:0] d);
        logic [DEN_W:0] t;
        t = {r, b};
        return t >= {1'b0, d} ? {1'b1, t[DEN_W-1:0] - d} : {1'b0, t[DEN_W-1:0]};
    endfunction

    // quotient never exceeds Q_W bits, so the upper numerator bits seed the remainder
    always_ff @(posedge clk) begin
        vld <= rst ? {vld[Q_W-2:0], in_valid} : '0;
        {qq[0], rem[0]} <= {(Q_W-1)'(0), step(DEN_W'(num[NUM_W-1:Q_W]), num[Q_W-1], den)};
        dq[0] <= den;
        nq[0] <= num;
        tq[0] <= in_tag;
        for (int i = 1; i < Q_W; i++) begin
            {qq[i], rem[i]} <= {qq[i-1][Q_W-2:0], step(rem[i-1], nq[i-1][Q_W-1-i], dq[i-1])};
            dq[i] <= dq[i-1];
            nq[i] <= nq[i-1];
            tq[i] <= tq[i-1];
        end
    end

    assign out_valid = vld[Q_W-1];
    assign quo = qq[Q_W-1];
    assign out_tag = tq[Q_W-1];
endmodule

// File: rtl/blft.sv
// blft: streaming 3x3 bilateral filter over a 256x256 raster frame, interior pixels only.
module blft #(
    parameter int DATA_W = blft_pkg::DATA_W,
    parameter int ADDR_W = blft_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data
);
    import blft_pkg::*;

    logic acc, live, v0, v1, v2, dv;
    logic [7:0] row, col;
    logic [DATA_W-1:0] lb_a [IMG_W];
    logic [DATA_W-1:0] lb_b [IMG_W];
    logic [DATA_W-1:0] win [9];
    logic [W_W-1:0] w0 [9];
    logic [W_W-1:0] w1 [9];
    logic [PROD_W-1:0] p0 [9];
    logic [PROD_W-1:0] p1 [9];
    logic [NUM_W-1:0] num, n2;
    logic [DEN_W-1:0] den, d2;
    logic [ADDR_W-1:0] a0, a1, a2, da;
    logic [DIV_STAGES-1:0] dq;

    assign acc = rst && in_valid;
    assign row = in_addr[ADDR_W-1:8];
    assign col = in_addr[7:0];

    // lb_a holds the previous row, lb_b the one before; win shifts one column per accepted pixel
    always_ff @(posedge clk) begin
        if (acc) begin
            lb_a[col] <= in_data;
            lb_b[col] <= lb_a[col];
            win <= '{win[1], win[2], lb_b[col], win[4], win[5], lb_a[col], win[7], win[8], in_data};
        end
    end

    always_comb begin
        for (int k = 0; k < 9; k++) begin
            w0[k] = ws_of(k) * range_w(win[k], win[4]);
            p0[k] = PROD_W'(w0[k]) * PROD_W'(win[k]);
        end
    end

    always_comb begin
        num = '0;
        den = '0;
        for (int k = 0; k < 9; k++) begin
            num = num + NUM_W'(p1[k]);
            den = den + DEN_W'(w1[k]);
        end
    end

    // window validity comes from the address alone, so a restart at 0 needs no flush
    always_ff @(posedge clk) begin
        live <= rst && (live || (in_valid && in_addr == '0));
        v0 <= acc && live && row >= 8'd2 && col >= 8'd2;
        v1 <= rst && v0;
        v2 <= rst && v1;
        a0 <= {row - 8'd1, col - 8'd1};
        a1 <= a0;
        a2 <= a1;
        w1 <= w0;
        p1 <= p0;
        n2 <= num + NUM_W'(den >> 1);
        d2 <= den;
        out_valid <= rst && dv;
        out_data <= rst && dv ? dq : '0;
        out_addr <= rst && dv ? da : '0;
    end

    blft_div #(
        .NUM_W(NUM_W),
        .DEN_W(DEN_W),
        .Q_W(DIV_STAGES),
        .TAG_W(ADDR_W)
    ) u_div (
        .clk(clk),
        .rst(rst),
        .in_valid(v2),
        .num(n2),
        .den(d2),
        .in_tag(a2),
        .out_valid(dv),
        .quo(dq),
        .out_tag(da)
    );
endmodule

// File: tb/tb_blft.sv
// tb_blft: directed checks of the bilateral filter, with a small reference model for a random patch.
module tb_blft;
    logic clk = 0;
    logic rst, in_valid, out_valid;
    logic [15:0] in_addr, out_addr;
    logic [8:0] in_data, out_data;

    int n_vec = 0, n_bad = 0;
    int cyc = 0;
    bit clr = 1;
    int n_out = 0, order_bad = 0, idle_bad = 0, first_a = -1, last_a = -1;
    int got_data [int];
    int got_cyc [int];
    int in_cyc [int];
    logic [8:0] rimg [1024];

    blft dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_addr(in_addr),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_addr(out_addr),
        .out_data(out_data)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (clr) begin
            got_data.delete();
            got_cyc.delete();
            n_out = 0;
            order_bad = 0;
            first_a = -1;
            last_a = -1;
        end else if (out_valid) begin
            if (int'(out_addr) <= last_a) order_bad++;
            if (first_a < 0) first_a = int'(out_addr);
            last_a = int'(out_addr);
            got_data[int'(out_addr)] = int'(out_data);
            got_cyc[int'(out_addr)] = cyc;
            n_out++;
        end else if (out_data !== 9'd0 || out_addr !== 16'd0) begin
            idle_bad++;
        end
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] img(input int kind, input int r, input int c);
        if (kind == 2) return rimg[r * 256 + c];
        if (kind == 0) return 9'd100;
        if (r >= 1 && r <= 3 && c >= 60 && c <= 62) return (r == 2 && c == 61) ? 9'd300 : 9'd0;
        if (r >= 2 && r <= 4 && c >= 49 && c <= 51) return (r == 3 && c == 50) ? 9'd100 : 9'd104;
        if (r == 2 && c == 2) return 9'd110;
        if (r == 2 && c == 10) return 9'd120;
        if (r == 2 && c == 20) return 9'd140;
        if (r == 2 && c == 30) return 9'd300;
        return 9'd100;
    endfunction

    function automatic int ref_px(input int r, input int c);
        int num = 0, den = 0, ic, pv, d, wr, ws;
        ic = int'(img(2, r, c));
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                pv = int'(img(2, r + dr, c + dc));
                d = pv > ic ? pv - ic : ic - pv;
                wr = d < 8 ? 8 : d < 16 ? 4 : d < 32 ? 2 : d < 64 ? 1 : 0;
                ws = (dr == 0 && dc == 0) ? 4 : (dr == 0 || dc == 0) ? 2 : 1;
                num += ws * wr * pv;
                den += ws * wr;
            end
        end
        return (num + den / 2) / den;
    endfunction

    function automatic int got(input int a);
        return got_data.exists(a) ? got_data[a] : -1;
    endfunction

    task automatic send(input int a, input logic [8:0] d, input int gap);
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1;
        in_addr = 16'(a);
        in_data = d;
        in_cyc[a] = cyc + 1;
        @(posedge clk);
        #1;
        in_valid = 0;
    endtask

    task automatic feed(input int kind, input int start, input int cnt, input bit gaps);
        for (int i = start; i < start + cnt; i++)
            send(i, img(kind, i >> 8, i & 255), (gaps && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0);
    endtask

    task automatic drain();
        repeat (20) @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr();
        clr = 1;
        @(negedge clk);
        #1;
        clr = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic frame_checks(input string tag, input int exp_n, input int exp_first, input int exp_last);
        int lat_bad = 0, src;
        foreach (got_cyc[a]) begin
            src = (((a >> 8) + 1) << 8) | ((a & 255) + 1);
            if (!in_cyc.exists(src) || got_cyc[a] - in_cyc[src] != 12) lat_bad++;
        end
        chk({tag, "_count"}, n_out, exp_n);
        chk({tag, "_first_addr"}, first_a, exp_first);
        chk({tag, "_last_addr"}, last_a, exp_last);
        chk({tag, "_order"}, order_bad, 0);
        chk({tag, "_latency"}, lat_bad, 0);
    endtask

    task automatic const_check(input string tag, input int val);
        int bad = 0;
        foreach (got_data[a]) if (got_data[a] != val) bad++;
        chk(tag, bad, 0);
    endtask

    initial begin
        rst = 0;
        in_valid = 0;
        in_addr = 0;
        in_data = 0;
        for (int i = 0; i < 1024; i++)
            rimg[i] = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(0, 511)) : 9'(200 + $urandom_range(0, 80));
        // inputs under reset, including address 0, must not start a frame
        for (int i = 0; i < 600; i++) begin
            in_valid = 1;
            in_addr = 16'(i);
            in_data = 9'(i);
            @(posedge clk);
            #1;
            if (i == 20) begin
                chk("reset_valid", out_valid, 0);
                chk("reset_data", out_data, 0);
                chk("reset_addr", out_addr, 0);
            end
        end
        in_valid = 0;
        clr = 0;
        rst = 1;
        feed(0, 600, 700, 0);
        drain();
        chk("no_frame_outputs", n_out, 0);

        // hand-computed weighting cases
        pulse_clr();
        feed(1, 0, 1280, 0);
        drain();
        frame_checks("feat", 762, 'h0101, 'h03FE);
        chk("corner_d10", got('h0101), 100);
        chk("edge_d10", got('h0201), 101);
        chk("centre_d10", got('h0202), 104);
        chk("centre_d20", got('h020A), 111);
        chk("centre_d40", got('h0214), 129);
        chk("centre_d200", got('h021E), 300);
        chk("next_to_300", got('h021F), 100);
        chk("centre_104_ring", got('h0332), 103);
        chk("lone_300_in_zero", got('h023D), 300);
        chk("zero_right_of_300", got('h023E), 0);
        chk("zero_left_of_300", got('h023C), 0);

        // restart at address 0 while results are still in flight
        pulse_clr();
        feed(0, 0, 1024, 0);
        feed(0, 0, 512, 0);
        drain();
        frame_checks("restart", 508, 'h0101, 'h02FE);
        const_check("restart_data", 100);

        // random patch with input gaps against the reference model
        pulse_clr();
        feed(2, 0, 1024, 1);
        drain();
        frame_checks("rand", 508, 'h0101, 'h02FE);
        for (int r = 1; r <= 2; r++)
            for (int c = 1; c <= 254; c++)
                chk($sformatf("rand_px(%0d,%0d)", r, c), got((r << 8) | c), ref_px(r, c));

        // reset mid-frame, then a complete frame
        pulse_clr();
        feed(0, 0, 1000, 0);
        chk("pre_reset_valid", out_valid, 1);
        chk("pre_reset_addr", out_addr, 'h02DA);
        rst = 0;
        in_valid = 1;
        in_addr = 16'd1000;
        in_data = 9'd100;
        @(posedge clk);
        #1;
        chk("mid_reset_valid", out_valid, 0);
        chk("mid_reset_data", out_data, 0);
        chk("mid_reset_addr", out_addr, 0);
        clr = 1;
        in_addr = 16'd1001;
        @(posedge clk);
        #1;
        clr = 0;
        in_addr = 16'd1002;
        @(posedge clk);
        #1;
        rst = 1;
        in_valid = 0;
        feed(0, 1003, 497, 0);
        drain();
        chk("after_reset_outputs", n_out, 0);
        pulse_clr();
        feed(0, 0, 65536, 0);
        drain();
        frame_checks("full", 64516, 'h0101, 'hFEFE);
        const_check("full_data", 100);

        chk("idle_outputs_zero", idle_bad, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
